// File: rtl/hi_lo_pkg.sv
// rtl/hi_lo_pkg.sv - op encodings, FSM states and iteration default for hi_lo_unit
package hi_lo_pkg;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    function automatic logic isSignedOp(input logic [2:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/hi_lo_unit_div_step.sv
// rtl/hi_lo_unit_div_step.sv - one restoring-division step: shift in a dividend bit, conditionally subtract
module div_step (
    input  logic [31:0] remIn,
    input  logic [31:0] quoIn,
    input  logic [31:0] divisor,
    output logic [31:0] remOut,
    output logic [31:0] quoOut
);
    logic [32:0] shifted;
    logic [32:0] diff;

    // remIn < divisor always holds, so bit 32 of diff is a clean borrow flag
    assign shifted = {remIn, quoIn[31]};
    assign diff    = shifted - {1'b0, divisor};
    assign remOut  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quoOut  = {quoIn[30:0], ~diff[32]};

endmodule

// File: rtl/hi_lo_unit.sv
// rtl/hi_lo_unit.sv - iterative HI/LO multiply/divide unit; divide datapath enabled by macro HI_LO_DIV_EN
module hi_lo_unit
    import hi_lo_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] ReadDataHi,
    output logic [31:0] ReadDataLo
);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_e           state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       opReg;
    logic [63:0]      work, stepNext, prodSigned, hiLoSum;
    logic [31:0]      opnd, hiReg, loReg, magA, magB;
    logic [32:0]      mulUpper;
    logic             negProd, divZero, opSigned, opIsDiv;

    assign opSigned   = isSignedOp(Op);
    assign opIsDiv    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign magA       = (opSigned && A[31]) ? -A : A;
    assign magB       = (opSigned && B[31]) ? -B : B;
    assign ReadDataHi = hiReg;
    assign ReadDataLo = loReg;
    assign hiLoSum    = {hiReg, loReg};
    assign prodSigned = negProd ? -work : work;

    // work = {partial product, remaining multiplier bits}; carry lands in bit 63 after the shift
    assign mulUpper = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);

`ifdef HI_LO_DIV_EN
    logic        negRem, opRegIsDiv;
    logic [31:0] divRem, divQuo;

    assign opRegIsDiv = (opReg == OP_DIV) || (opReg == OP_DIVU);

    div_step uDivStep (
        .remIn  (work[63:32]),
        .quoIn  (work[31:0]),
        .divisor(opnd),
        .remOut (divRem),
        .quoOut (divQuo)
    );

    assign stepNext = opRegIsDiv ? {divRem, divQuo} : {mulUpper, work[31:1]};
`else
    assign stepNext = {mulUpper, work[31:1]};
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        DivByZero = 1'b0;
        case (state)
            IDLE: if (Start && !(Op inside {OP_MTHI, OP_MTLO})) begin
`ifdef HI_LO_DIV_EN
                stateNext = (opIsDiv && B == '0) ? DONE : RUN;
`else
                stateNext = opIsDiv ? DONE : RUN;
`endif
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == LAST_CNT) stateNext = FIX;
            end
            FIX: begin
                Busy      = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                DivByZero = divZero;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt     <= '0;
            opReg   <= '0;
            work    <= '0;
            opnd    <= '0;
            negProd <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
`ifdef HI_LO_DIV_EN
            negRem  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (Start) begin
                    opReg   <= Op;
                    cnt     <= '0;
                    negProd <= opSigned & (A[31] ^ B[31]);
                    divZero <= 1'b0;
                    case (Op)
                        OP_MTHI: hiReg <= A;
                        OP_MTLO: loReg <= A;
                        OP_DIV, OP_DIVU: begin
`ifdef HI_LO_DIV_EN
                            work    <= {32'd0, magA};
                            opnd    <= magB;
                            negRem  <= opSigned & A[31];
                            divZero <= (B == '0);
`endif
                        end
                        default: begin
                            work <= {32'd0, magB};
                            opnd <= magA;
                        end
                    endcase
                end
                RUN: begin
                    work <= stepNext;
                    cnt  <= cnt + CNT_W'(1);
                end
                FIX: case (opReg)
                    OP_MULT, OP_MULTU: {hiReg, loReg} <= prodSigned;
                    OP_MADD:           {hiReg, loReg} <= hiLoSum + prodSigned;
                    OP_MSUB:           {hiReg, loReg} <= hiLoSum - prodSigned;
`ifdef HI_LO_DIV_EN
                    OP_DIV, OP_DIVU: begin
                        loReg <= negProd ? -work[31:0] : work[31:0];
                        hiReg <= negRem ? -work[63:32] : work[63:32];
                    end
`endif
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
// tb/tb_hi_lo_unit.sv - scoreboard testbench for hi_lo_unit against a behavioural HI/LO model
module tb_hi_lo_unit;
    import hi_lo_pkg::*;

    localparam int ITER = 32;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] ReadDataHi, ReadDataLo;

    hi_lo_unit #(.ITER(ITER)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .ReadDataHi(ReadDataHi),
        .ReadDataLo(ReadDataLo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          startCyc;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: architectural HI/LO updated with plain 64-bit arithmetic
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output exp_t e, output bit hasDone);
        logic [63:0] acc, p, uq, ur;
        longint      q, r;
        acc     = {mHi, mLo};
        p       = (op == OP_MULTU) ? {32'd0, a} * {32'd0, b}
                                   : 64'(longint'($signed(a)) * longint'($signed(b)));
        e.lat   = ITER + 2;
        e.dbz   = 1'b0;
        hasDone = 1'b1;
        case (op)
            OP_MULT, OP_MULTU: acc = p;
            OP_MADD:           acc = acc + p;
            OP_MSUB:           acc = acc - p;
            OP_DIV, OP_DIVU: begin
`ifdef HI_LO_DIV_EN
                if (b == 0) begin
                    e.lat = 1;
                    e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    q   = longint'($signed(a)) / longint'($signed(b));
                    r   = longint'($signed(a)) % longint'($signed(b));
                    acc = {r[31:0], q[31:0]};
                end else begin
                    uq  = {32'd0, a} / {32'd0, b};
                    ur  = {32'd0, a} % {32'd0, b};
                    acc = {ur[31:0], uq[31:0]};
                end
`else
                e.lat = 1;
`endif
            end
            OP_MTHI: begin acc[63:32] = a; hasDone = 1'b0; end
            default: begin acc[31:0]  = a; hasDone = 1'b0; end
        endcase
        mHi  = acc[63:32];
        mLo  = acc[31:0];
        e.hi = mHi;
        e.lo = mLo;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge Clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        exp_t e;
        bit   hasDone;
        modelOp(op, a, b, e, hasDone);
        e.name = name;
        @(negedge Clk);
        Op = op; A = a; B = b; Start = 1'b1;
        e.startCyc = cyc;
        if (hasDone) expQ.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        if (hasDone) begin
            repeat (e.lat - 1) @(negedge Clk);
        end else begin
            check({name, "_hi"}, ReadDataHi, mHi);
            check({name, "_lo"}, ReadDataLo, mLo);
            check({name, "_busy"}, Busy, 0);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Done) begin
            if (expQ.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = expQ.pop_front();
                check({e.name, "_hi"}, ReadDataHi, e.hi);
                check({e.name, "_lo"}, ReadDataLo, e.lo);
                check({e.name, "_dbz"}, DivByZero, e.dbz);
                check({e.name, "_latency"}, 64'(cyc - e.startCyc), 64'(e.lat));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        bit          hd;
        int          s;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge Clk);
        #1;
        check("reset_hi", ReadDataHi, 0);
        check("reset_lo", ReadDataLo, 0);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_dbz", DivByZero, 0);

        // first Start presented together with reset release
        @(negedge Clk);
        Rst = 1'b1; Op = OP_MTHI; A = 32'h12345678; Start = 1'b1;
        mHi = 32'h12345678;
        @(negedge Clk);
        Start = 1'b0;
        check("first_start_hi", ReadDataHi, 32'h12345678);
        check("first_start_busy", Busy, 0);

        issue(OP_MTLO, 32'h9ABCDEF0, 32'h0, "mtlo");
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, "mult_neg2x3");
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, "multu_fffffffex3");
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, "div_neg7by2");
        issue(OP_DIVU, 32'd7, 32'd0, "divu_by0");
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min_by_neg1");
        issue(OP_MTHI, 32'h0, 32'h0, "mthi0");
        issue(OP_MTLO, 32'hFFFFFFFF, 32'h0, "mtlo_ones");
        issue(OP_MADD, 32'd1, 32'd1, "madd_carry");
        issue(OP_MSUB, 32'd1, 32'd1, "msub_borrow");

        // DIV request during a MULT must be ignored
        modelOp(OP_MULT, 32'h00012345, 32'hFFFF0003, e, hd);
        e.name = "mult_with_ignored_div";
        @(negedge Clk);
        Op = OP_MULT; A = 32'h00012345; B = 32'hFFFF0003; Start = 1'b1;
        s = cyc; e.startCyc = s;
        expQ.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        waitUntil(s + 5);
        Op = OP_DIV; A = 32'd100; B = 32'd0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        waitUntil(s + ITER + 2);

        // reset mid-operation aborts with HI/LO cleared and no Done
        @(negedge Clk);
        Op = OP_MULT; A = 32'd5; B = 32'd7; Start = 1'b1;
        s = cyc;
        @(negedge Clk);
        Start = 1'b0;
        waitUntil(s + 5);
        Op = OP_DIV; A = 32'd100; B = 32'd3; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        waitUntil(s + 10);
        check("abort_busy_running", Busy, 1);
        waitUntil(s + 20);
        Rst = 1'b0;
        #1;
        check("abort_hi", ReadDataHi, 0);
        check("abort_lo", ReadDataLo, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        mHi = '0;
        mLo = '0;
        @(negedge Clk);
        Rst = 1'b1;
        waitUntil(s + ITER + 6);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
        end

        waitUntil(cyc + ITER + 5);
        check("pending_done_queue", 64'(expQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hi_lo_unit.md
HI_LO_UNIT -- requirements
Module: hi_lo_unit

Interface
REQ-001 The block SHALL have one parameter: ITER, default 32, number of iteration cycles per multiply/divide.
REQ-002 Port Clk SHALL be: input, 1 bit, single clock, rising-edge.
REQ-003 Port Rst SHALL be: input, 1 bit, reset, asynchronous, active-low.
REQ-004 Port Start SHALL be: input, 1 bit, one-cycle operation request.
REQ-005 Port Op SHALL be: input, 3 bits, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
REQ-006 Port A SHALL be: input, 32 bits, rs operand; dividend / multiplicand / move source.
REQ-007 Port B SHALL be: input, 32 bits, rt operand; divisor / multiplier.
REQ-008 Port Busy SHALL be: output, 1 bit, iterative operation in progress.
REQ-009 Port Done SHALL be: output, 1 bit, one-cycle completion pulse.
REQ-010 Port DivByZero SHALL be: output, 1 bit, qualified by Done.
REQ-011 Ports ReadDataHi and ReadDataLo SHALL be: outputs, 32 bits each, architectural HI and LO, registered; they feed the write-back stage.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX, DONE.
REQ-013 Start SHALL be accepted only in IDLE; Start in any other state SHALL be ignored and SHALL NOT corrupt the running operation.
REQ-014 MTHI/MTLO SHALL write A into HI/LO at the accepting edge, stay in IDLE, and assert neither Busy nor Done.
REQ-015 MULT/MULTU/MADD/MSUB/DIV/DIVU SHALL latch A and B, go IDLE->RUN, and hold Busy=1 in RUN and FIX.
REQ-016 RUN SHALL last exactly ITER cycles: one shift-add (multiply) or restoring subtract (divide) per cycle, on operand magnitudes for signed ops; then go RUN->FIX.
REQ-017 FIX SHALL apply sign correction and write HI/LO in one cycle, then go FIX->DONE; DONE SHALL assert Done=1, Busy=0 for one cycle, then return to IDLE.
REQ-018 Total latency from the Start edge to Done SHALL be ITER+2 cycles; HI/LO SHALL hold their previous values until the FIX edge.
REQ-019 MULT/MULTU SHALL write {HI,LO} = 64-bit signed/unsigned product.
REQ-020 MADD/MSUB SHALL write {HI,LO} = {HI,LO} +/- signed 64-bit product, wrapping modulo 2^64.
REQ-021 DIV/DIVU SHALL write LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 Divide with B=0 SHALL skip RUN/FIX (IDLE->DONE), leave HI/LO unchanged, and assert DivByZero=1 with Done; DivByZero SHALL otherwise be 0.
REQ-024 Rst asserted mid-operation SHALL abort it with no HI/LO update and no Done pulse.

Reset
REQ-025 Rst low SHALL asynchronously force state IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0, and clear the working registers.
REQ-026 The first Start SHALL be accepted on the first rising edge after Rst deasserts.

Configuration
REQ-027 With macro HI_LO_DIV_EN defined, DIV/DIVU SHALL behave as in REQ-021..023.
REQ-028 Without HI_LO_DIV_EN, the divide datapath SHALL be absent; DIV/DIVU SHALL go IDLE->DONE, pulse Done with DivByZero=0, and leave HI/LO unchanged.

Structure
REQ-029 Package hi_lo_pkg SHALL hold the Op encodings, the FSM state type, and the ITER default.
REQ-030 One combinational sub-module, div_step (restoring subtract/shift of one quotient bit), SHALL exist, instantiated only under HI_LO_DIV_EN.
REQ-031 The multiply step and all state SHALL remain in hi_lo_unit.

Verification
REQ-032 Reset then MTHI A=0x12345678, MTLO A=0x9ABCDEF0 -> next cycle ReadDataHi=0x12345678, ReadDataLo=0x9ABCDEF0, Busy never high.
REQ-033 MULT A=0xFFFFFFFE (-2), B=3 -> Done at cycle 34 after Start, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-034 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> Done after 1 cycle, DivByZero=1, HI/LO unchanged.
REQ-035 HI=0, LO=0xFFFFFFFF then MADD A=1, B=1 -> HI=1, LO=0; then MSUB A=1, B=1 -> HI=0, LO=0xFFFFFFFF.
REQ-036 Start MULT, pulse Start with DIV at cycle 5, assert Rst at cycle 20 -> DIV ignored; after Rst HI=LO=0, no Done pulse, state IDLE.
